// File: rtl/iiq_sched_pkg.sv
// Shared types and helpers for the integer issue queue scheduler.
// Holds default sizes, the per-slot metadata struct and the wakeup tag matcher.
package iiq_sched_pkg;

  localparam int IIQ_N_ENTRIES   = 8;
  localparam int IIQ_ENTRY_WIDTH = 32;
  localparam int ROB_ID_WIDTH    = 6;
  localparam int IIQ_N_WAKEUP    = 2;

  typedef struct packed {
    logic                    valid;
    logic [ROB_ID_WIDTH-1:0] src1_tag;
    logic                    src1_rdy;
    logic [ROB_ID_WIDTH-1:0] src2_tag;
    logic                    src2_rdy;
  } iiq_sched_entry_t;

  // True when any valid broadcast port carries the given tag.
  function automatic logic tag_match(
    input logic [IIQ_N_WAKEUP-1:0]                   vld,
    input logic [IIQ_N_WAKEUP-1:0][ROB_ID_WIDTH-1:0] tags,
    input logic [ROB_ID_WIDTH-1:0]                   tag
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < IIQ_N_WAKEUP; j++) begin
      if (vld[j] && (tags[j] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/onehot_lsb_picker.sv
// One-hot grant of the lowest-index set request bit (all zeros if none).
// Ports: req_i request vector, gnt_o one-hot grant.
module onehot_lsb_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Two's-complement isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/iiq_issue_scheduler.sv
// Scheduler for the integer issue shift queue: metadata shadow, wakeup,
// oldest-ready select and a one-entry issue slot toward the integer FU.
// Ports: enq_* dispatch side, wakeup_* broadcasts, deq_* queue select/data,
// issue_* FU handshake, entry_count shadow occupancy.
module iiq_issue_scheduler
  import iiq_sched_pkg::*;
#(
  parameter  int N_ENTRIES   = IIQ_N_ENTRIES,
  parameter  int ENTRY_WIDTH = IIQ_ENTRY_WIDTH,
  parameter  int TAG_WIDTH   = ROB_ID_WIDTH,
  parameter  int N_WAKEUP    = IIQ_N_WAKEUP,
  localparam int CTR_WIDTH   = $clog2(N_ENTRIES) + 1
) (
  input  logic                               clk,
  input  logic                               rst_aL,
  input  logic                               enq_fire,
  input  logic [TAG_WIDTH-1:0]               enq_src1_tag,
  input  logic                               enq_src1_rdy,
  input  logic [TAG_WIDTH-1:0]               enq_src2_tag,
  input  logic                               enq_src2_rdy,
  input  logic [N_WAKEUP-1:0]                wakeup_valid,
  input  logic [N_WAKEUP-1:0][TAG_WIDTH-1:0] wakeup_tag,
  output logic                               deq_ready,
  output logic [N_ENTRIES-1:0]               deq_sel_onehot,
  input  logic [ENTRY_WIDTH-1:0]             deq_data,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [ENTRY_WIDTH-1:0]             issue_data,
  output logic [CTR_WIDTH-1:0]               entry_count
);

  iiq_sched_entry_t [N_ENTRIES-1:0] slot_q;
  iiq_sched_entry_t [N_ENTRIES-1:0] slot_d;
  // Slot N is a constant empty entry so the shift reads slot i+1 uniformly.
  iiq_sched_entry_t [N_ENTRIES:0]   slot_ext;
  iiq_sched_entry_t                 enq_entry;
  iiq_sched_entry_t                 nxt;

  logic [CTR_WIDTH-1:0]   count_q;
  logic [CTR_WIDTH-1:0]   count_d;
  logic [CTR_WIDTH-1:0]   enq_pos;
  logic                   issue_valid_q;
  logic [ENTRY_WIDTH-1:0] issue_data_q;

  logic                 slot_free;
  logic                 deq;
  logic [N_ENTRIES-1:0] elig;
  logic [N_ENTRIES-1:0] gnt;
  logic [N_ENTRIES-1:0] shift_ge;
  logic [N_ENTRIES-1:0] valid_vec;
  logic [N_ENTRIES-1:0] run_mask;
  logic                 acc;

  always_comb begin
    elig      = '0;
    valid_vec = '0;
    run_mask  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      valid_vec[i] = slot_q[i].valid;
      elig[i]      = slot_q[i].valid & slot_q[i].src1_rdy
                   & slot_q[i].src2_rdy;
      run_mask[i]  = (CTR_WIDTH'(i) < count_q);
    end
  end

  onehot_lsb_picker #(
    .N (N_ENTRIES)
  ) u_pick (
    .req_i (elig),
    .gnt_o (gnt)
  );

  assign slot_free      = ~issue_valid_q | issue_ready;
  assign deq_ready      = slot_free;
  assign deq_sel_onehot = slot_free ? gnt : '0;
  assign deq            = |deq_sel_onehot;

  // Slots at and above the dequeued index move down by one.
  always_comb begin
    shift_ge = '0;
    acc      = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      acc         = acc | deq_sel_onehot[i];
      shift_ge[i] = acc;
    end
  end

  // A same-cycle broadcast is folded into the new entry's ready bits.
  always_comb begin
    enq_entry          = '0;
    enq_entry.valid    = 1'b1;
    enq_entry.src1_tag = enq_src1_tag;
    enq_entry.src2_tag = enq_src2_tag;
    enq_entry.src1_rdy = enq_src1_rdy
      | tag_match(wakeup_valid, wakeup_tag, enq_src1_tag);
    enq_entry.src2_rdy = enq_src2_rdy
      | tag_match(wakeup_valid, wakeup_tag, enq_src2_tag);
  end

  assign enq_pos  = deq ? (count_q - CTR_WIDTH'(1)) : count_q;
  assign slot_ext = {iiq_sched_entry_t'('0), slot_q};

  // Shift, then insert, then wake: an entry moving down keeps
  // any wakeup it matched in the same cycle.
  always_comb begin
    slot_d = slot_q;
    nxt    = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      nxt = shift_ge[i] ? slot_ext[i+1] : slot_ext[i];
      if (enq_fire && (enq_pos == CTR_WIDTH'(i))) begin
        nxt = enq_entry;
      end
      if (nxt.valid) begin
        nxt.src1_rdy = nxt.src1_rdy
          | tag_match(wakeup_valid, wakeup_tag, nxt.src1_tag);
        nxt.src2_rdy = nxt.src2_rdy
          | tag_match(wakeup_valid, wakeup_tag, nxt.src2_tag);
      end
      slot_d[i] = nxt;
    end
  end

  assign count_d = count_q + CTR_WIDTH'(enq_fire) - CTR_WIDTH'(deq);

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      slot_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
      if (deq) begin
        issue_valid_q <= 1'b1;
        issue_data_q  <= deq_data;
      end else if (issue_ready) begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_data  = issue_data_q;
  assign entry_count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_aL)
    !(enq_fire && (count_q == CTR_WIDTH'(N_ENTRIES)) && !deq));

  a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_aL)
    $onehot0(deq_sel_onehot));

  a_elig_valid: assert property (@(posedge clk) disable iff (!rst_aL)
    ((elig & ~valid_vec) == '0));

  a_valid_run: assert property (@(posedge clk) disable iff (!rst_aL)
    (valid_vec == run_mask));

endmodule

// File: tb/tb_iiq_issue_scheduler.sv
// Self-checking bench for iiq_issue_scheduler: directed table, corner
// sequences and random traffic against a queue-level reference model.
module tb_iiq_issue_scheduler;

  localparam int N  = 8;
  localparam int EW = 32;
  localparam int TW = 6;

  logic              clk = 1'b0;
  logic              rst_aL;
  logic              enq_fire;
  logic [TW-1:0]     enq_src1_tag;
  logic              enq_src1_rdy;
  logic [TW-1:0]     enq_src2_tag;
  logic              enq_src2_rdy;
  logic [1:0]        wakeup_valid;
  logic [1:0][TW-1:0] wakeup_tag;
  logic              deq_ready;
  logic [N-1:0]      deq_sel_onehot;
  logic [EW-1:0]     deq_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [EW-1:0]     issue_data;
  logic [3:0]        entry_count;
  logic [EW-1:0]     enq_pay;

  always #5 clk = ~clk;

  iiq_issue_scheduler #(
    .N_ENTRIES   (N),
    .ENTRY_WIDTH (EW),
    .TAG_WIDTH   (TW),
    .N_WAKEUP    (2)
  ) dut (
    .clk            (clk),
    .rst_aL         (rst_aL),
    .enq_fire       (enq_fire),
    .enq_src1_tag   (enq_src1_tag),
    .enq_src1_rdy   (enq_src1_rdy),
    .enq_src2_tag   (enq_src2_tag),
    .enq_src2_rdy   (enq_src2_rdy),
    .wakeup_valid   (wakeup_valid),
    .wakeup_tag     (wakeup_tag),
    .deq_ready      (deq_ready),
    .deq_sel_onehot (deq_sel_onehot),
    .deq_data       (deq_data),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_data     (issue_data),
    .entry_count    (entry_count)
  );

  typedef struct {
    logic [TW-1:0] t1;
    bit            r1;
    logic [TW-1:0] t2;
    bit            r2;
    logic [EW-1:0] pay;
  } ment_t;

  ment_t         mq[$];
  bit            m_iv;
  logic [EW-1:0] m_idata;
  logic [EW-1:0] mpay[N];

  int n_tests = 0;
  int n_fail  = 0;

  // Payload queue emulation: return the selected slot's payload.
  always_comb begin
    deq_data = '0;
    for (int i = 0; i < N; i++) begin
      if (deq_sel_onehot[i]) deq_data = mpay[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit woke(input logic [TW-1:0] t);
    return (wakeup_valid[0] && wakeup_tag[0] == t)
        || (wakeup_valid[1] && wakeup_tag[1] == t);
  endfunction

  // Oldest entry whose sources are both ready, if the slot can take it.
  function automatic int m_pick();
    if (m_iv && !issue_ready) return -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r1 && mq[i].r2) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_sel();
    int k;
    logic [N-1:0] s;
    k = m_pick();
    s = '0;
    if (k >= 0) s[k] = 1'b1;
    return s;
  endfunction

  task automatic drive(input bit en, input logic [TW-1:0] t1, input bit r1,
                       input logic [TW-1:0] t2, input bit r2,
                       input logic [EW-1:0] pay, input logic [1:0] wv,
                       input logic [TW-1:0] w0, input logic [TW-1:0] w1,
                       input bit ir);
    enq_fire      = en;
    enq_src1_tag  = t1;
    enq_src1_rdy  = r1;
    enq_src2_tag  = t2;
    enq_src2_rdy  = r2;
    enq_pay       = pay;
    wakeup_valid  = wv;
    wakeup_tag[0] = w0;
    wakeup_tag[1] = w1;
    issue_ready   = ir;
  endtask

  task automatic idle(input bit ir);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 2'b00, '0, '0, ir);
  endtask

  task automatic eval();
    @(negedge clk);
    chk("deq_sel", 64'(deq_sel_onehot), 64'(m_sel()));
    chk("deq_ready", 64'(deq_ready), 64'(!m_iv || issue_ready));
    chk("issue_valid", 64'(issue_valid), 64'(m_iv));
    chk("issue_data", 64'(issue_data), 64'(m_idata));
    chk("entry_count", 64'(entry_count), 64'(mq.size()));
  endtask

  task automatic adv();
    int k;
    ment_t e;
    k = m_pick();
    if (!rst_aL) begin
      mq.delete();
      m_iv    = 1'b0;
      m_idata = '0;
    end else begin
      if (k >= 0) begin
        m_iv    = 1'b1;
        m_idata = mq[k].pay;
        mq.delete(k);
      end else if (issue_ready) begin
        m_iv = 1'b0;
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (woke(mq[i].t1)) mq[i].r1 = 1'b1;
        if (woke(mq[i].t2)) mq[i].r2 = 1'b1;
      end
      if (enq_fire) begin
        e.t1  = enq_src1_tag;
        e.r1  = enq_src1_rdy || woke(enq_src1_tag);
        e.t2  = enq_src2_tag;
        e.r2  = enq_src2_rdy || woke(enq_src2_tag);
        e.pay = enq_pay;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mpay[i] = (i < mq.size()) ? mq[i].pay : '0;
    end
  endtask

  typedef struct {
    bit            enq;
    logic [TW-1:0] t1;
    bit            r1;
    logic [TW-1:0] t2;
    bit            r2;
    logic [EW-1:0] pay;
    logic [1:0]    wv;
    logic [TW-1:0] wt0;
    bit            ir;
    logic [N-1:0]  e_sel;
    bit            e_iv;
    logic [EW-1:0] e_data;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hA1, 2'b00, 6'd0, 1'b1,
                8'h00, 1'b0, 32'h00, 4'd0};
    tbl[1]  = '{1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hB2, 2'b00, 6'd0, 1'b1,
                8'h01, 1'b0, 32'h00, 4'd1};
    tbl[2]  = '{1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'hC3, 2'b00, 6'd0, 1'b1,
                8'h01, 1'b1, 32'hA1, 4'd1};
    tbl[3]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h00, 2'b00, 6'd0, 1'b1,
                8'h01, 1'b1, 32'hB2, 4'd1};
    tbl[4]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h00, 2'b00, 6'd0, 1'b1,
                8'h00, 1'b1, 32'hC3, 4'd0};
    tbl[5]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h00, 2'b00, 6'd0, 1'b1,
                8'h00, 1'b0, 32'hC3, 4'd0};
    tbl[6]  = '{1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 32'h1A, 2'b00, 6'd0, 1'b1,
                8'h00, 1'b0, 32'hC3, 4'd0};
    tbl[7]  = '{1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'h2B, 2'b00, 6'd0, 1'b1,
                8'h00, 1'b0, 32'hC3, 4'd1};
    tbl[8]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h00, 2'b00, 6'd0, 1'b1,
                8'h02, 1'b0, 32'hC3, 4'd2};
    tbl[9]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h00, 2'b01, 6'd5, 1'b1,
                8'h00, 1'b1, 32'h2B, 4'd1};
    tbl[10] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h00, 2'b00, 6'd0, 1'b1,
                8'h01, 1'b0, 32'h2B, 4'd1};
    tbl[11] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h00, 2'b00, 6'd0, 1'b1,
                8'h00, 1'b1, 32'h1A, 4'd0};

    for (int i = 0; i < N; i++) mpay[i] = '0;
    m_iv    = 1'b0;
    m_idata = '0;

    // Reset
    rst_aL = 1'b0;
    idle(1'b1);
    adv();
    adv();
    rst_aL = 1'b1;
    @(negedge clk);
    chk("rst_sel", 64'(deq_sel_onehot), 64'h0);
    chk("rst_deq_ready", 64'(deq_ready), 64'h1);
    chk("rst_issue_valid", 64'(issue_valid), 64'h0);
    chk("rst_issue_data", 64'(issue_data), 64'h0);
    chk("rst_count", 64'(entry_count), 64'h0);
    adv();

    // Directed table: in-order issue, then wakeup-driven reorder
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].enq, tbl[i].t1, tbl[i].r1, tbl[i].t2, tbl[i].r2,
            tbl[i].pay, tbl[i].wv, tbl[i].wt0, 6'd0, tbl[i].ir);
      eval();
      chk($sformatf("tbl%0d_sel", i), 64'(deq_sel_onehot),
          64'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_iv", i), 64'(issue_valid), 64'(tbl[i].e_iv));
      chk($sformatf("tbl%0d_data", i), 64'(issue_data),
          64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_cnt", i), 64'(entry_count),
          64'(tbl[i].e_cnt));
      adv();
    end

    // Same-cycle wakeup on port 1 for enqueued src2
    drive(1'b1, 6'd3, 1'b1, 6'd9, 1'b0, 32'h99, 2'b10, 6'd0, 6'd9, 1'b1);
    eval();
    adv();
    idle(1'b1);
    eval();
    chk("samecyc_sel", 64'(deq_sel_onehot), 64'h01);
    adv();
    eval();
    chk("samecyc_issue", 64'({issue_valid, issue_data}),
        64'({1'b1, 32'h99}));
    adv();
    for (int i = 0; i < 2; i++) begin eval(); adv(); end

    // Fill to N with the FU stalled
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'(100 + i), 2'b00,
            6'd0, 6'd0, 1'b0);
      eval();
      adv();
    end
    idle(1'b0);
    eval();
    chk("full_sel", 64'(deq_sel_onehot), 64'h0);
    chk("full_cnt", 64'(entry_count), 64'd8);
    chk("full_issue", 64'(issue_data), 64'd100);
    adv();
    drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'd200, 2'b00, 6'd0, 6'd0, 1'b1);
    eval();
    chk("full_deq_sel", 64'(deq_sel_onehot), 64'h01);
    adv();
    idle(1'b0);
    eval();
    chk("full_enq_cnt", 64'(entry_count), 64'd8);
    chk("full_enq_issue", 64'(issue_data), 64'd101);
    adv();
    idle(1'b1);
    for (int i = 0; i < 12; i++) begin eval(); adv(); end

    // Wakeup while the matching entry shifts from slot 3 to slot 2
    drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'h300, 2'b00, 6'd0, 6'd0, 1'b0);
    eval(); adv();
    drive(1'b1, 6'd20, 1'b0, 6'd2, 1'b1, 32'h301, 2'b00, 6'd0, 6'd0, 1'b0);
    eval(); adv();
    drive(1'b1, 6'd21, 1'b0, 6'd2, 1'b1, 32'h302, 2'b00, 6'd0, 6'd0, 1'b0);
    eval(); adv();
    drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'h303, 2'b00, 6'd0, 6'd0, 1'b0);
    eval(); adv();
    drive(1'b1, 6'd7, 1'b0, 6'd2, 1'b1, 32'h304, 2'b00, 6'd0, 6'd0, 1'b0);
    eval(); adv();
    idle(1'b0);
    eval();
    chk("shift_cnt", 64'(entry_count), 64'd4);
    adv();
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0, 2'b01, 6'd7, 6'd0, 1'b1);
    eval();
    chk("shift_sel0", 64'(deq_sel_onehot), 64'h04);
    adv();
    idle(1'b1);
    eval();
    chk("shift_sel1", 64'(deq_sel_onehot), 64'h04);
    adv();
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0, 2'b11, 6'd20, 6'd21, 1'b1);
    eval(); adv();
    idle(1'b1);
    for (int i = 0; i < 6; i++) begin eval(); adv(); end

    // Reset mid-stream with a held issue slot
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'(500 + i), 2'b00,
            6'd0, 6'd0, 1'b0);
      eval();
      adv();
    end
    idle(1'b0);
    eval();
    chk("prerst_state", 64'({issue_valid, entry_count}),
        64'({1'b1, 4'd4}));
    adv();
    rst_aL = 1'b0;
    drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 32'd999, 2'b01, 6'd1, 6'd0, 1'b1);
    eval();
    adv();
    rst_aL = 1'b1;
    idle(1'b1);
    eval();
    chk("midrst_iv", 64'(issue_valid), 64'h0);
    chk("midrst_cnt", 64'(entry_count), 64'h0);
    chk("midrst_sel", 64'(deq_sel_onehot), 64'h0);
    adv();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      bit ir;
      bit en;
      rst_aL = ($urandom_range(0, 499) != 0);
      ir = ($urandom_range(0, 3) != 0);
      issue_ready = ir;
      en = ($urandom_range(0, 2) != 0)
        && ((mq.size() < N) || (m_pick() >= 0));
      drive(en, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom, 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), ir);
      eval();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
